clock_set_uart_rx: RTL and testbench
====================================

# clock_set_uart_rx

Serial time-set receiver for the digital clock. It receives an ASCII time string "HHMMSS" followed by CR (0x0D) on a single UART line and validates every digit and field range. It then presents a one-cycle load strobe with binary hours/minutes/seconds to the clock counter core. It sits between a `ui_in` pin and the core's preset inputs, and is the inbound end of the clock's serial time interface.

## Interface
- `CLK_HZ`, default 10_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: UART bit rate. `DIV = CLK_HZ/BAUD` (integer division) must be ≥ 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- `rx`  in  1  asynchronous UART line, idle high, 8N1 (8E1 with macro), LSB first.
- `load_valid`  out  1  one-cycle pulse; a valid time was received.
- `load_hh`  out  5  hours 0–23, binary; valid while `load_valid`=1, otherwise holds the last loaded value.
- `load_mm`  out  6  minutes 0–59, binary, same hold rule.
- `load_ss`  out  6  seconds 0–59, binary, same hold rule.
- `err`  out  1  one-cycle pulse on framing, parity, character or range error.
- `busy`  out  1  high from start-bit detection until a string completes or is discarded.

## Operation
- `rx` passes through a 2-flop synchronizer. All edge and sample logic uses the synchronized value `rxs`.
- Bit engine states:
  - IDLE: a falling edge on `rxs` goes to START and loads the bit counter with DIV/2−1.
  - START: at counter expiry, if `rxs`=0 go to DATA with counter DIV−1. If `rxs`=1 it is a glitch: return to IDLE with no `err`.
  - DATA: sample 8 bits, one every DIV clocks, shifting LSB first, then go to STOP (or PARITY with the macro).
  - STOP: sample once; `rxs`=1 hands the byte to the parser; `rxs`=0 pulses `err`, resets the parser, and returns to IDLE.
- Parser holds a digit index 0–6 and a 6-digit BCD buffer:
  - Index 0–5: byte 0x30–0x39 is stored and the index increments. 0x0A at index 0 is ignored. Any other byte pulses `err` and resets the index to 0.
  - Index 6: 0x0D triggers a range check (HH≤23, MM≤59, SS≤59). Pass: convert BCD to binary, register the outputs, pulse `load_valid`. Fail: pulse `err`. Any other byte at index 6 pulses `err`. The index returns to 0 in every case.
- `busy` = (bit engine ≠ IDLE) OR (parser index ≠ 0).
- `load_valid` and `err` are never high in the same cycle.
- Reset values: `load_valid`=0, `err`=0, `busy`=0, `load_hh`/`load_mm`/`load_ss`=0. Bit engine goes to IDLE and the parser index to 0.

## Timing
- START check occurs DIV/2 clocks after the synchronized falling edge. Each later sample follows DIV clocks after the previous one.
- `load_valid`/`err` assert exactly 1 clock after the stop-bit sample cycle and last exactly 1 clock.
- Total latency from the CR stop-bit center on the pin to `load_valid` is 3 clocks: 2 synchronizer clocks plus 1 register clock.
- A new start bit is accepted in the cycle after the stop sample; the engine does not wait a full stop-bit time.
- `rst_n` low mid-frame or mid-string: state is discarded with no `err` or `load_valid` pulse, and the block is idle on the first clock after release.
- Bytes may arrive with arbitrary idle gaps between them; the parser has no timeout.

## Configuration
- `CLKSET_PARITY_EN` defined: the frame is 8E1. A PARITY state follows DATA and samples one bit. If the XOR of the 8 data bits and the parity bit is 1, pulse `err`, reset the parser, and return to IDLE without a STOP check.
- Not defined: the frame is 8N1, there is no PARITY state, and STOP follows DATA directly.

## Test plan
All tests use CLK_HZ=1000 and BAUD=100, so DIV=10.
- Reset, then send "123456" plus 0x0D. Expect one `load_valid` pulse with `load_hh`=12, `load_mm`=34, `load_ss`=56, no `err`, and `busy`=0 afterward.
- Send "235959" plus 0x0D, then 0x0A, then "000000" plus 0x0D. Expect two `load_valid` pulses: first 23/59/59, then 0/0/0.
- Send "240000" plus 0x0D. Expect one `err` pulse, no `load_valid`, and outputs still at their previous values.
- Send "12:" then "345600" plus 0x0D. Expect one `err` on ':', and `load_valid` must not follow from this string alone.
- Send byte 0x31 with the stop bit forced to 0. Expect `err` 1 clock after the stop sample. Separately, send a 3-clock low glitch on `rx`; expect no `err`, and `busy` must return to 0.
- Assert `rst_n` low during bit 4 of the fourth digit. Expect no pulse on either output, all outputs 0, and a following valid "010203" plus 0x0D to load 1/2/3.
- With `CLKSET_PARITY_EN`, send a digit with a wrong parity bit. Expect `err`.

Source files
------------

// File: rtl/clock_set_uart_rx.sv
// ============================================================================
// clock_set_uart_rx
// ----------------------------------------------------------------------------
// Serial time-set receiver for the digital clock. It receives the ASCII string
// "HHMMSS" followed by CR (0x0D) on a UART line and checks every character
// and every field range. A good string produces a one-cycle load strobe with
// binary hours/minutes/seconds for the clock counter core.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    UART bit rate; DIV = CLK_HZ/BAUD must be >= 4
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   rx          in   asynchronous UART line, idle high, LSB first
//   load_valid  out  one-cycle pulse: a valid time was received
//   load_hh     out  hours 0-23 (holds the last loaded value)
//   load_mm     out  minutes 0-59 (holds the last loaded value)
//   load_ss     out  seconds 0-59 (holds the last loaded value)
//   err         out  one-cycle pulse on framing/parity/character/range error
//   busy        out  high while a frame or a partial string is in progress
//
// Build option:
//   CLKSET_PARITY_EN  defined -> 8E1 frames with a parity check;
//                     undefined -> 8N1 frames.
// ============================================================================
module clock_set_uart_rx #(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       load_valid,
    output logic [4:0] load_hh,
    output logic [5:0] load_mm,
    output logic [5:0] load_ss,
    output logic       err,
    output logic       busy
);

    localparam int DIV = CLK_HZ / BAUD;
    // DIV-1 always fits in clog2(DIV) bits
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronizer and edge history
    logic          r_rx_meta;
    logic          r_rxs;
    logic          r_rxs_d;

    // Bit engine
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bitn;
    logic [7:0]    r_shift;

    // Parser
    logic [2:0]    r_idx;
    logic [3:0]    r_digit [0:5];

    // Registered outputs
    logic          r_load_valid;
    logic          r_err;
    logic [4:0]    r_hh;
    logic [5:0]    r_mm;
    logic [5:0]    r_ss;

    logic          w_tick;
    logic          w_fall;
    logic          w_byte_ok;
    logic          w_stop_err;
    logic          w_par_err;
    logic          w_frame_err;
    logic          w_is_digit;
    logic          w_range_ok;
    logic [6:0]    w_field [0:2];

    assign w_tick = (r_cnt == '0);
    assign w_fall = r_rxs_d & ~r_rxs;

    // Stop-bit outcome: good stop hands the byte over, bad stop is a frame error
    assign w_byte_ok  = (r_state == S_STOP) && w_tick && r_rxs;
    assign w_stop_err = (r_state == S_STOP) && w_tick && !r_rxs;

`ifdef CLKSET_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero
    assign w_par_err = (r_state == S_PARITY) && w_tick && (^{r_shift, r_rxs});
`else
    assign w_par_err = 1'b0;
`endif

    assign w_frame_err = w_stop_err | w_par_err;
    assign w_is_digit  = (r_shift >= 8'h30) && (r_shift <= 8'h39);

    // BCD pair -> binary for each field (0: hours, 1: minutes, 2: seconds)
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_field
            assign w_field[gi] = 7'(r_digit[2*gi]) * 7'd10 + 7'(r_digit[2*gi+1]);
        end
    endgenerate

    assign w_range_ok = (w_field[0] <= 7'd23) && (w_field[1] <= 7'd59) &&
                        (w_field[2] <= 7'd59);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rxs        <= 1'b1;
            r_rxs_d      <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bitn       <= '0;
            r_shift      <= '0;
            r_idx        <= '0;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;
            r_hh         <= '0;
            r_mm         <= '0;
            r_ss         <= '0;
        end else begin
            r_rx_meta    <= rx;
            r_rxs        <= r_rx_meta;
            r_rxs_d      <= r_rxs;
            r_load_valid <= 1'b0;
            r_err        <= 1'b0;

            // ---------------- bit engine ----------------
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_cnt   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!r_rxs) begin
                            r_state <= S_DATA;
                            r_cnt   <= FULL_LOAD;
                            r_bitn  <= '0;
                        end else begin
                            // Line came back high: treat as a glitch, silently
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rxs, r_shift[7:1]};
                        r_cnt   <= FULL_LOAD;
                        r_bitn  <= r_bitn + 3'd1;
                        if (r_bitn == 3'd7) begin
`ifdef CLKSET_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef CLKSET_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_cnt   <= FULL_LOAD;
                        r_state <= w_par_err ? S_IDLE : S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Return to IDLE right after the sample so the next start
                    // edge can be caught without waiting a full stop bit
                    if (w_tick) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // ---------------- parser ----------------
            if (w_frame_err) begin
                r_err <= 1'b1;
                r_idx <= '0;
            end else if (w_byte_ok) begin
                if (r_idx == 3'd6) begin
                    r_idx <= '0;
                    if ((r_shift == 8'h0D) && w_range_ok) begin
                        r_load_valid <= 1'b1;
                        r_hh         <= w_field[0][4:0];
                        r_mm         <= w_field[1][5:0];
                        r_ss         <= w_field[2][5:0];
                    end else begin
                        r_err <= 1'b1;
                    end
                end else if (w_is_digit) begin
                    r_digit[r_idx] <= r_shift[3:0];
                    r_idx          <= r_idx + 3'd1;
                end else if ((r_idx == 3'd0) && (r_shift == 8'h0A)) begin
                    // LF between strings is tolerated
                    r_idx <= '0;
                end else begin
                    r_err <= 1'b1;
                    r_idx <= '0;
                end
            end
        end
    end

    assign load_valid = r_load_valid;
    assign err        = r_err;
    assign load_hh    = r_hh;
    assign load_mm    = r_mm;
    assign load_ss    = r_ss;
    assign busy       = (r_state != S_IDLE) || (r_idx != 3'd0);

endmodule

// File: tb/tb_clock_set_uart_rx.sv
// ============================================================================
// tb_clock_set_uart_rx
// Table-driven strings, hand-written corner sequences and random strings,
// all checked against a character-level model of the time-set protocol.
// In stimulus strings '^' stands for CR (0x0D) and '|' for LF (0x0A).
// ============================================================================
module tb_clock_set_uart_rx;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef CLKSET_PARITY_EN
    localparam int NBITS  = 11;
`else
    localparam int NBITS  = 10;
`endif
    // Pulse cycle relative to the cycle the start bit is driven:
    // 2 synchronizer flops + half-bit start check + whole bits, then 1 register
    localparam int EV_OFF     = (NBITS - 1) * DIV + 8;
    localparam int PAR_ERR_OFF = 9 * DIV + 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       load_valid;
    logic [4:0] load_hh;
    logic [5:0] load_mm;
    logic [5:0] load_ss;
    logic       err;
    logic       busy;

    clock_set_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .load_valid (load_valid),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .load_ss    (load_ss),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_load;
        int hh;
        int mm;
        int ss;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        got_q[$];
    logic [7:0] pend[$];
    ev_t        mon_ev;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // Record every output pulse
    always @(negedge clk) begin
        if (rst_n && (load_valid || err)) begin
            chk("exclusive_pulse", int'(load_valid && err), 0);
            mon_ev.cyc     = cyc;
            mon_ev.is_load = load_valid;
            mon_ev.hh      = int'(load_hh);
            mon_ev.mm      = int'(load_mm);
            mon_ev.ss      = int'(load_ss);
            got_q.push_back(mon_ev);
        end
    end

    // ---------------- reference model (character level) ----------------
    function automatic int dig(input int i);
        return int'(pend[i]) - 48;
    endfunction

    function automatic void model_err(input int c);
        ev_t e;
        e.cyc = c; e.is_load = 1'b0; e.hh = 0; e.mm = 0; e.ss = 0;
        pend.delete();
        exp_q.push_back(e);
    endfunction

    function automatic void model_byte(input logic [7:0] b, input int c);
        ev_t e;
        e.cyc = c; e.is_load = 1'b0; e.hh = 0; e.mm = 0; e.ss = 0;
        if (pend.size() < 6) begin
            if (b >= 8'h30 && b <= 8'h39) begin
                pend.push_back(b);
            end else if (!(b == 8'h0A && pend.size() == 0)) begin
                model_err(c);
            end
        end else begin
            if (b == 8'h0D) begin
                e.hh = dig(0) * 10 + dig(1);
                e.mm = dig(2) * 10 + dig(3);
                e.ss = dig(4) * 10 + dig(5);
                e.is_load = (e.hh <= 23) && (e.mm <= 59) && (e.ss <= 59);
            end
            pend.delete();
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [7:0] xlat(input logic [7:0] ch);
        if (ch == 8'h5E) return 8'h0D;
        if (ch == 8'h7C) return 8'h0A;
        return ch;
    endfunction

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop_val, input bit par_flip);
        int start_c;
        @(negedge clk);
        start_c = cyc;
`ifdef CLKSET_PARITY_EN
        if (par_flip)       model_err(start_c + PAR_ERR_OFF);
        else if (!stop_val) model_err(start_c + EV_OFF);
        else                model_byte(b, start_c + EV_OFF);
`else
        if (!stop_val || par_flip) model_err(start_c + EV_OFF);
        else                       model_byte(b, start_c + EV_OFF);
`endif
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
`ifdef CLKSET_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (DIV) @(negedge clk);
`endif
        rx = stop_val;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        if (!stop_val) repeat (2 * DIV) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(xlat(s[i]), 1'b1, 1'b0);
            repeat ($urandom_range(max_gap)) @(negedge clk);
        end
    endtask

    task automatic compare_events(input string name);
        ev_t e;
        ev_t g;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk({name, "_kind"}, int'(g.is_load), int'(e.is_load));
            chk({name, "_cycle"}, g.cyc, e.cyc);
            if (e.is_load) begin
                chk({name, "_hh"}, g.hh, e.hh);
                chk({name, "_mm"}, g.mm, e.mm);
                chk({name, "_ss"}, g.ss, e.ss);
            end
        end
        chk({name, "_extra_pulses"}, got_q.size(), 0);
        chk({name, "_missing_pulses"}, exp_q.size(), 0);
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string txt;
        int    n_load;
        int    n_err;
        int    hh;
        int    mm;
        int    ss;
    } vec_t;

    localparam int NV = 11;
    vec_t tv [NV];

    initial begin
        int nl;
        int ne;
        logic [7:0] c3;
        string pool;
        string s;

        tv[0]  = '{"123456^",         1, 0, 12, 34, 56};
        tv[1]  = '{"235959^|000000^", 2, 0,  0,  0,  0};
        tv[2]  = '{"240000^",         0, 1,  0,  0,  0};
        tv[3]  = '{"12:345600^",      0, 2,  0,  0,  0};
        tv[4]  = '{"010203^",         1, 0,  1,  2,  3};
        tv[5]  = '{"1234567",         0, 1,  1,  2,  3};
        tv[6]  = '{"||203040^",       1, 0, 20, 30, 40};
        tv[7]  = '{"12|",             0, 1, 20, 30, 40};
        tv[8]  = '{"236059^",         0, 1, 20, 30, 40};
        tv[9]  = '{"235960^",         0, 1, 20, 30, 40};
        tv[10] = '{"^",               0, 1, 20, 30, 40};

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_load_valid", int'(load_valid), 0);
        chk("rst_err",        int'(err), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_hh",         int'(load_hh), 0);
        chk("rst_mm",         int'(load_mm), 0);
        chk("rst_ss",         int'(load_ss), 0);

        for (int v = 0; v < NV; v++) begin
            exp_q.delete();
            got_q.delete();
            send_str(tv[v].txt, 3);
            repeat (30) @(negedge clk);
            nl = 0;
            ne = 0;
            foreach (got_q[k]) begin
                if (got_q[k].is_load) nl++;
                else                  ne++;
            end
            chk($sformatf("v%0d_loads", v), nl, tv[v].n_load);
            chk($sformatf("v%0d_errs", v),  ne, tv[v].n_err);
            chk($sformatf("v%0d_hh", v),    int'(load_hh), tv[v].hh);
            chk($sformatf("v%0d_mm", v),    int'(load_mm), tv[v].mm);
            chk($sformatf("v%0d_ss", v),    int'(load_ss), tv[v].ss);
            chk($sformatf("v%0d_busy", v),  int'(busy), 0);
            compare_events($sformatf("v%0d", v));
        end

        // Bad stop bit on '1'
        send_byte(8'h31, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        chk("badstop_busy", int'(busy), 0);
        compare_events("badstop");

        // 3-clock glitch: engine wakes, then falls back silently
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_high", int'(busy), 1);
        rx = 1'b1;
        repeat (15) @(negedge clk);
        chk("glitch_busy_low", int'(busy), 0);
        compare_events("glitch");

        // Reset during bit 4 of the fourth digit
        send_str("012", 2);
        chk("mid_string_busy", int'(busy), 1);
        c3 = 8'h33;
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            repeat (DIV) @(negedge clk);
        end
        rx = c3[4];
        repeat (DIV / 2) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        pend.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_load_valid", int'(load_valid), 0);
        chk("rstmid_err", int'(err), 0);
        chk("rstmid_hh", int'(load_hh), 0);
        chk("rstmid_mm", int'(load_mm), 0);
        chk("rstmid_ss", int'(load_ss), 0);
        repeat (20) @(negedge clk);
        compare_events("rstmid");
        send_str("010203^", 2);
        repeat (20) @(negedge clk);
        chk("after_rst_hh", int'(load_hh), 1);
        chk("after_rst_mm", int'(load_mm), 2);
        chk("after_rst_ss", int'(load_ss), 3);
        compare_events("after_rst");

`ifdef CLKSET_PARITY_EN
        send_byte(8'h35, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("parity_busy", int'(busy), 0);
        compare_events("parity");
`endif

        // Random strings against the model
        pool = "0123456789:|^AZ/";
        for (int r = 0; r < 12; r++) begin
            int kind;
            int h;
            int m;
            int sc;
            int badpos;
            kind = $urandom_range(3);
            if (kind == 1) begin
                h  = $urandom_range(99);
                m  = $urandom_range(99);
                sc = $urandom_range(99);
            end else begin
                h  = $urandom_range(23);
                m  = $urandom_range(59);
                sc = $urandom_range(59);
            end
            s = $sformatf("%02d%02d%02d^", h, m, sc);
            if (kind == 2) s[$urandom_range(6)] = pool[$urandom_range(15)];
            badpos = (kind == 3) ? $urandom_range(6) : -1;
            for (int i = 0; i < s.len(); i++) begin
                send_byte(xlat(s[i]), (i != badpos), 1'b0);
                repeat ($urandom_range(12)) @(negedge clk);
            end
            repeat (20) @(negedge clk);
            chk($sformatf("rnd%0d_busy", r), int'(busy), int'(pend.size() != 0));
            compare_events($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
